// File: rtl/md_ctrl.sv
// HI/LO multiply-divide sequencer for the E stage: computes mult/div results on
// start, holds them for a fixed latency, then commits them to HI/LO.
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  md_op_E,
    input  logic [31:0] rs_data_E,
    input  logic [31:0] rt_data_E,
    input  logic        md_instr_D,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi_lo_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    // state   | meaning
    // ST_IDLE | no operation in flight; md ops in E are executed
    // ST_BUSY | result pending in pend_hi/pend_lo, count running down to commit
    typedef enum logic { ST_IDLE, ST_BUSY } state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] LP_MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] LP_DIV_CNT  = 4'(DIV_CYCLES);

    state_t              r_state;
    state_t              w_state_nxt;
    logic   [3:0]        r_count;
    logic   [31:0]       r_hi;
    logic   [31:0]       r_lo;
    logic   [31:0]       r_pend_hi;
    logic   [31:0]       r_pend_lo;
    logic                r_div0;
    logic                w_busy;
    logic                w_start;
    logic                w_load;
    logic                w_commit;
    logic                w_is_div;
    logic   [31:0]       w_res_hi;
    logic   [31:0]       w_res_lo;
    logic signed [63:0]  w_prod_s;
    logic   [63:0]       w_prod_u;
    logic                w_div_ovf;
    logic   [31:0]       w_divisor_s;
    logic   [31:0]       w_divisor_u;
    logic signed [31:0]  w_quo_s;
    logic signed [31:0]  w_rem_s;
    logic   [31:0]       w_quo_u;
    logic   [31:0]       w_rem_u;

    assign w_busy   = (r_state == ST_BUSY);
    assign w_start  = (md_op_E >= OP_MULT) && (md_op_E <= OP_DIVU) && !w_busy;
    assign w_is_div = (md_op_E == OP_DIV) || (md_op_E == OP_DIVU);

    assign w_prod_s = $signed(rs_data_E) * $signed(rt_data_E);
    assign w_prod_u = {32'd0, rs_data_E} * {32'd0, rt_data_E};

    // Substitute divisor 1 for the cases whose native result is undefined; the
    // most-negative / -1 case then yields exactly the architectural answer.
    assign w_div_ovf   = (rs_data_E == 32'h8000_0000) && (rt_data_E == 32'hFFFF_FFFF);
    assign w_divisor_s = ((rt_data_E == 32'd0) || w_div_ovf) ? 32'd1 : rt_data_E;
    assign w_divisor_u = (rt_data_E == 32'd0) ? 32'd1 : rt_data_E;
    assign w_quo_s     = $signed(rs_data_E) / $signed(w_divisor_s);
    assign w_rem_s     = $signed(rs_data_E) % $signed(w_divisor_s);
    assign w_quo_u     = rs_data_E / w_divisor_u;
    assign w_rem_u     = rs_data_E % w_divisor_u;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (md_op_E)
            OP_MULT:  begin w_res_hi = w_prod_s[63:32];  w_res_lo = w_prod_s[31:0]; end
            OP_MULTU: begin w_res_hi = w_prod_u[63:32];  w_res_lo = w_prod_u[31:0]; end
            OP_DIV:   begin w_res_hi = w_rem_s;          w_res_lo = w_quo_s;        end
            OP_DIVU:  begin w_res_hi = w_rem_u;          w_res_lo = w_quo_u;        end
            default:  ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: if (w_start) begin
                w_state_nxt = ST_BUSY;
                w_load      = 1'b1;
            end
            ST_BUSY: if (r_count == 4'd1) begin
                w_state_nxt = ST_IDLE;
                w_commit    = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count   <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_div0    <= 1'b0;
        end else begin
            if (w_load) begin
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_count   <= w_is_div ? LP_DIV_CNT : LP_MULT_CNT;
                r_div0    <= w_is_div && (rt_data_E == 32'd0);
            end else if (w_busy) begin
                r_count <= r_count - 4'd1;
            end
            // md ops arriving while busy fall through both branches untouched
            if (w_commit && !r_div0) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end else if (!w_busy) begin
                if (md_op_E == OP_MTHI) r_hi <= rs_data_E;
                if (md_op_E == OP_MTLO) r_lo <= rs_data_E;
            end
        end
    end

    assign busy      = w_busy;
    assign md_stall  = md_instr_D && (w_busy || w_start);
    assign hi_lo_out = (md_op_E == OP_MFHI) ? r_hi :
                       (md_op_E == OP_MFLO) ? r_lo : 32'd0;
    assign hi        = r_hi;
    assign lo        = r_lo;
endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: table of arithmetic ops plus hand sequences for
// stall timing, MTHI/MFHI forwarding, divide by zero and mid-operation reset.
module tb_md_ctrl;
    logic        clk;
    logic        reset;
    logic [3:0]  md_op_E;
    logic [31:0] rs_data_E;
    logic [31:0] rt_data_E;
    logic        md_instr_D;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi_lo_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .md_op_E(md_op_E), .rs_data_E(rs_data_E),
        .rt_data_E(rt_data_E), .md_instr_D(md_instr_D), .busy(busy),
        .md_stall(md_stall), .hi_lo_out(hi_lo_out), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs[9];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count busy cycles after a start edge; also checks HI is still old on the first busy cycle.
    task automatic wait_busy(output int n, input logic [31:0] old_hi, input string nm);
        int g;
        n = 0;
        g = 0;
        while (busy && g < 40) begin
            n++;
            g++;
            if (n == 1) chk({nm, "_hi_held"}, hi, old_hi);
            tick();
        end
    endtask

    initial begin
        int n;
        int g;
        logic seen;

        vecs[0] = '{"mult_neg",   4'd1, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 5};
        vecs[1] = '{"multu_max",  4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
        vecs[2] = '{"div_m7_2",   4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        vecs[3] = '{"div_ovf",    4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        vecs[4] = '{"divu_100_7", 4'd4, 32'd100,       32'd7,        32'd2,         32'd14,        10};
        vecs[5] = '{"multu_2p32", 4'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};
        vecs[6] = '{"div_7_m2",   4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 10};
        vecs[7] = '{"divu_max_2", 4'd4, 32'hFFFF_FFFF, 32'd2,        32'd1,         32'h7FFF_FFFF, 10};
        vecs[8] = '{"mult_minsq", 4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};

        reset = 1'b0;
        md_op_E = 4'd0;
        rs_data_E = 32'd0;
        rt_data_E = 32'd0;
        md_instr_D = 1'b0;
        tick();
        tick();
        md_instr_D = 1'b1;
        md_op_E = 4'd5;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, md_stall}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_mfhi", hi_lo_out, 32'd0);
        reset = 1'b1;
        md_op_E = 4'd0;
        md_instr_D = 1'b0;
        tick();
        m_hi = 32'd0;
        m_lo = 32'd0;

        for (int i = 0; i < 9; i++) begin
            md_op_E = vecs[i].op;
            rs_data_E = vecs[i].rs;
            rt_data_E = vecs[i].rt;
            #1;
            chk({vecs[i].name, "_idle"}, {31'd0, busy}, 32'd0);
            tick();
            md_op_E = 4'd0;
            rs_data_E = 32'hA5A5_A5A5;
            rt_data_E = 32'd0;
            wait_busy(n, m_hi, vecs[i].name);
            chk({vecs[i].name, "_cycles"}, 32'(n), 32'(vecs[i].cyc));
            chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            m_hi = vecs[i].exp_hi;
            m_lo = vecs[i].exp_lo;
        end

        // MULT in E with MFLO in D: stall in start cycle plus every busy cycle
        md_op_E = 4'd1;
        rs_data_E = 32'd3;
        rt_data_E = 32'd4;
        md_instr_D = 1'b1;
        #1;
        n = md_stall ? 1 : 0;
        chk("start_stall", {31'd0, md_stall}, 32'd1);
        tick();
        md_op_E = 4'd0;
        #1;
        g = 0;
        while (md_stall && g < 40) begin
            n++;
            g++;
            tick();
        end
        chk("stall_cycles", 32'(n), 32'd6);
        md_op_E = 4'd6;
        md_instr_D = 1'b0;
        #1;
        chk("mflo_after_mult", hi_lo_out, 32'd12);
        chk("mflo_no_stall", {31'd0, md_stall}, 32'd0);
        tick();

        // MTHI then MFHI back to back, MFHI in D during MTHI
        md_op_E = 4'd7;
        rs_data_E = 32'h1234_5678;
        md_instr_D = 1'b1;
        #1;
        chk("mthi_stall", {31'd0, md_stall}, 32'd0);
        tick();
        md_op_E = 4'd5;
        md_instr_D = 1'b0;
        rs_data_E = 32'd0;
        #1;
        chk("mfhi_fwd", hi_lo_out, 32'h1234_5678);
        chk("mfhi_stall", {31'd0, md_stall}, 32'd0);
        tick();
        md_op_E = 4'd8;
        rs_data_E = 32'hCAFE_0001;
        tick();
        md_op_E = 4'd6;
        #1;
        chk("mflo_fwd", hi_lo_out, 32'hCAFE_0001);
        tick();

        // MULT, then ADDU in D and an ignored MTHI while busy
        md_op_E = 4'd1;
        rs_data_E = 32'd2;
        rt_data_E = 32'd3;
        tick();
        md_op_E = 4'd7;
        rs_data_E = 32'hDEAD_BEEF;
        md_instr_D = 1'b0;
        #1;
        chk("addu_no_stall", {31'd0, md_stall}, 32'd0);
        chk("busy_mid", {31'd0, busy}, 32'd1);
        tick();
        md_op_E = 4'd0;
        wait_busy(n, 32'h1234_5678, "mult_viol");
        chk("viol_hi", hi, 32'd0);
        chk("viol_lo", lo, 32'd6);

        // Set HI, then DIVU by zero leaves HI/LO untouched
        md_op_E = 4'd7;
        rs_data_E = 32'h1234_5678;
        tick();
        md_op_E = 4'd4;
        rs_data_E = 32'd77;
        rt_data_E = 32'd0;
        tick();
        md_op_E = 4'd0;
        wait_busy(n, 32'h1234_5678, "divu0");
        chk("divu0_cycles", 32'(n), 32'd10);
        chk("divu0_hi", hi, 32'h1234_5678);
        chk("divu0_lo", lo, 32'd6);

        // Reset asserted in the 4th busy cycle of DIV
        md_op_E = 4'd3;
        rs_data_E = 32'd100;
        rt_data_E = 32'd3;
        tick();
        md_op_E = 4'd0;
        md_instr_D = 1'b1;
        tick();
        tick();
        tick();
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_stall", {31'd0, md_stall}, 32'd0);
        chk("async_hi", hi, 32'd0);
        chk("async_lo", lo, 32'd0);
        tick();
        reset = 1'b1;
        md_instr_D = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (busy || hi != 32'd0 || lo != 32'd0) seen = 1'b1;
        end
        chk("no_late_commit", {31'd0, seen}, 32'd0);
        md_op_E = 4'd5;
        #1;
        chk("mfhi_after_rst", hi_lo_out, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide controller for the E stage of the five-stage pipeline. It sequences the HI/LO multiply-divide resource: it accepts one mult/div/move operation per cycle from the E stage and models fixed multi-cycle latency with a countdown. It holds HI/LO and returns them to the E-stage result path, and it raises a stall request that the D-stage hazard logic ORs into the existing `stall`.

## Interface

**Parameters**
- MULT_CYCLES, default 5: busy cycles for MULT/MULTU (legal range 1..15).
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU (legal range 1..15).

**Ports**
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- md_op_E  in  4  operation of the instruction in E: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9..15 are treated as NONE.
- rs_data_E  in  32  forwarded rs operand (dividend/multiplicand; MTHI/MTLO source).
- rt_data_E  in  32  forwarded rt operand (divisor/multiplier).
- md_instr_D  in  1  the instruction in D is any md-class op (codes 1..8).
- busy  out  1  an operation is in flight.
- md_stall  out  1  stall request for the F/D registers and E bubble.
- hi_lo_out  out  32  HI for MFHI, LO for MFLO, 0 otherwise; combinational.
- hi  out  32  current HI register.
- lo  out  32  current LO register.

## Operation

- State: `hi`, `lo`, `pend_hi`, `pend_lo`, a 4-bit `count`, and a `busy` flag.
- start_E = (md_op_E in 1..4) and not busy.
- On start_E:
  - Compute the result from `rs_data_E`/`rt_data_E` into `pend_hi`/`pend_lo`.
  - Load `count` with MULT_CYCLES or DIV_CYCLES and set `busy`.
- Arithmetic:
  - MULT: signed 32x32 to 64 bits; HI = [63:32], LO = [31:0].
  - MULTU: same, unsigned.
  - DIV: signed; LO = quotient truncated toward zero, HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO = 0x80000000, HI = 0.
  - Divide by zero (DIV/DIVU): runs the full DIV_CYCLES with `busy` high, then commits nothing; HI/LO are unchanged.
- While `busy`:
  - `count` decrements each cycle.
  - On the cycle `count` == 1, the next edge copies `pend_hi`/`pend_lo` into `hi`/`lo` (unless divide by zero) and clears `busy`.
- MTHI/MTLO:
  - Write `rs_data_E` to `hi`/`lo` at the edge ending the cycle they occupy E.
  - They are accepted only when not busy; the stall guarantees this.
- MFHI/MFLO: `hi_lo_out` reflects the current register value combinationally; the value is not affected by a pending result.
- Any md op (1..8) in E while `busy` is a protocol violation: it is ignored, with no state change. The stall makes this unreachable.
- md_stall = md_instr_D and (busy or start_E).
- Reset (asserted low, at any time, including mid-operation):
  - `hi` = `lo` = 0 and `pend_*` = 0.
  - `count` = 0, `busy` = 0, so `md_stall` = 0 and `hi_lo_out` = 0.
  - Any in-flight result is discarded.

## Timing

- Edge t0 ends the cycle in which MULT is in E:
  - `busy` is 1 in cycles t0+1 .. t0+MULT_CYCLES.
  - `hi`/`lo` hold the new value from cycle t0+MULT_CYCLES+1, the same cycle `busy` returns to 0.
  - DIV is identical, using DIV_CYCLES.
- `md_stall` is 1 in the start cycle itself (start_E) whenever D holds an md op. This covers back-to-back mult/mfhi with no gap.
- A D-stage md op may first advance in cycle t0+N+1.
  - Example: MFLO directly behind MULT enters E with `busy` = 0 and reads the new LO.
- An MTHI followed immediately by MFHI needs no stall; the MFHI in E reads the value written at the preceding edge.
- Only md ops stall. Non-md instructions flow through D/E while `busy`.
- Back-to-back starts:
  - A second start is accepted in the first cycle with `busy` = 0.
  - The commit edge and the new-start edge never coincide.
- Reset is asynchronous and takes effect without a clock. Release is synchronous to the next rising edge.

## Test plan

- MULT, rs = 0xFFFFFFFD (-3), rt = 5 -> `busy` is high for exactly 5 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. DIV -7/2 -> after 10 busy cycles LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- MULT in E, MFLO in D -> `md_stall` = 1 in the start cycle plus 5 busy cycles (6 total); MFLO then returns LO = product low word.
- MTHI 0x12345678 then MFHI next cycle -> `hi_lo_out` = 0x12345678 with `md_stall` = 0 throughout. DIVU x/0 with HI = 0x12345678 -> `busy` runs 10 cycles; HI/LO are unchanged.
- reset pulled low in the 4th busy cycle of DIV -> `busy`, `md_stall`, `hi`, `lo` are 0 immediately. After release, MFHI returns 0 and no late commit occurs.
- ADDU in D while `busy` -> `md_stall` = 0. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
